logit_approx: RTL and testbench
===============================

LOGIT_APPROX -- requirements
Module: logit_approx

Interface
REQ-001 Parameter: MAX_SHIFT, default 7, maximum normalization shift count (integer part ceiling).
REQ-002 Parameter: FRAC_SHIFT, default 2, left-shift applied to the normalized residue to form the Q8.8 fraction.
REQ-003 clk  input  1  single rising-edge clock.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 ena  input  1  block enable; low freezes all state.
REQ-006 in_valid  input  1  y_in valid.
REQ-007 in_ready  output  1  block can accept y_in.
REQ-008 y_in  input  16  probability, unsigned Q8.8 (0x0100 = 1.0).
REQ-009 out_valid  output  1  x_out valid.
REQ-010 out_ready  input  1  consumer accepts x_out.
REQ-011 x_out  output  16  logit estimate, signed two's-complement Q8.8.

Function
REQ-012 The block shall invert the team's piecewise-linear sigmoid: region, then shift-count integer part, then linear fraction.
REQ-013 Transfer on the input side when in_valid && in_ready && ena; on the output side when out_valid && out_ready && ena.
REQ-014 FSM states IDLE, NORM, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 IDLE, on input transfer: if y_in >= 0x0080 then sign=positive, t = 0x0100 - y_in; else sign=negative, t = y_in[7:0]; k=0; go to NORM.
REQ-016 Saturation on load: y_in == 0x0000 shall produce x_out = 0x8000; y_in >= 0x0100 shall produce x_out = 0x7FFF; both go directly to DONE.
REQ-017 NORM, each enabled cycle: if t[7]==1 or k==MAX_SHIFT, compute the result and go to DONE; otherwise t <= t<<1, k <= k+1.
REQ-018 Result: frac = min((t - 0x80) << FRAC_SHIFT, 0xFF); magnitude = {k[7:0], frac}; x_out = magnitude if positive, else two's complement of magnitude.
REQ-019 DONE: hold x_out and out_valid stable until the output transfer, then go to IDLE; no new input accepted in DONE.
REQ-020 Latency from the input-transfer edge to out_valid high shall be 2+k cycles (iterative mode) and 1 cycle for saturated inputs.
REQ-021 With ena low, state, t, k and x_out shall hold; handshakes shall not complete.
REQ-022 Arithmetic shall use 9-bit internal width for t and residue shifts so that no intermediate wraps.

Reset
REQ-023 On rst_n low, asynchronously: state=IDLE, x_out=0x0000, t=0, k=0, sign=0; therefore in_ready=1 and out_valid=0.
REQ-024 Reset asserted mid-NORM or in DONE shall discard the pending result; no out_valid after release until a new input.

Configuration
REQ-025 Macro LOGIT_FAST_NORM_EN: when defined, NORM shall complete in one cycle using a leading-one detector (k = leading-zero count of t, capped at MAX_SHIFT), giving a fixed latency of 2 cycles; when undefined, it uses iterative one-shift-per-cycle normalization per REQ-017. x_out values shall be identical in both builds.

Structure
REQ-026 A shared package logit_pkg shall hold the state enum and the constants HALF=0x0080, ONE=0x0100, SAT_POS=0x7FFF, SAT_NEG=0x8000.
REQ-027 One sub-module, logit_norm, shall contain the normalizer (iterative shifter or leading-one detector selected by the macro); FSM and handshake shall stay in logit_approx.

Verification
REQ-028 y_in=0x0080 -> positive, t=0x80, k=0 -> x_out=0x0000, out_valid 2 cycles after accept.
REQ-029 y_in=0x0020 -> negative, k=2, frac=0 -> x_out=0xFE00; latency 4 cycles iterative, 2 cycles with LOGIT_FAST_NORM_EN.
REQ-030 y_in=0x00D0 -> t=0x30, k=2, t_norm=0xC0, frac clamped 0xFF -> x_out=0x02FF.
REQ-031 y_in=0x0000 -> x_out=0x8000; y_in=0x0140 -> x_out=0x7FFF; each with 1-cycle latency.
REQ-032 out_ready held low for 5 cycles after out_valid -> x_out stable, in_ready=0 throughout; next input accepted only after the output transfer.
REQ-033 rst_n pulsed low during NORM for y_in=0x0001 -> outputs return to reset values immediately; no out_valid until a fresh input is accepted.

Source files
------------

// File: rtl/logit_pkg.sv
// ============================================================================
// Module      : logit_pkg
// Description : Shared state encoding, constants and helpers for logit_approx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package logit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] HALF    = 16'h0080;
    localparam logic [15:0] ONE     = 16'h0100;
    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;

    // Nine bits hold t = ONE - HALF without wrapping during normalization.
    localparam int T_W = 9;
    localparam int K_W = 8;

    function automatic logic [7:0] clamp_frac(input logic [15:0] v);
        return (v > 16'h00FF) ? 8'hFF : v[7:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/logit_approx_if.sv
// ============================================================================
// Module      : logit_approx_if
// Description : Input/output valid-ready handshake bundle for logit_approx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface logit_approx_if;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] y_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] x_out;

    modport master (
        output in_valid,
        output y_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  x_out
    );

    modport slave (
        input  in_valid,
        input  y_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output x_out
    );

endinterface

`default_nettype wire

// File: rtl/logit_norm.sv
// ============================================================================
// Module      : logit_norm
// Description : Residue normalizer; iterative shifter by default, single-cycle
//               leading-one detector when LOGIT_FAST_NORM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logit_norm
    import logit_pkg::*;
#(
    parameter int MAX_SHIFT = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    input  logic           load,
    input  logic           run,
    input  logic [T_W-1:0] t_in,
    output logic           done,
    output logic [K_W-1:0] k_out,
    output logic [T_W-1:0] t_norm
);

    localparam logic [K_W-1:0] C_MAX_K = K_W'(MAX_SHIFT);

    logic [T_W-1:0] r_t;

`ifdef LOGIT_FAST_NORM_EN

    logic [K_W-1:0] w_lz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_t <= '0;
        end else if (ena && load) begin
            r_t <= t_in;
        end
    end

    // Highest set bit wins because it is visited last.
    always_comb begin
        w_lz = K_W'(8);
        for (int i = 0; i < 8; i++) begin
            if (r_t[i]) begin
                w_lz = K_W'(7 - i);
            end
        end
        if (r_t[T_W-1]) begin
            w_lz = '0;
        end
        if (w_lz > C_MAX_K) begin
            w_lz = C_MAX_K;
        end
    end

    assign done   = run;
    assign k_out  = w_lz;
    assign t_norm = r_t << w_lz;

`else

    logic [K_W-1:0] r_k;

    assign done = run && (r_t[T_W-1] || r_t[7] || (r_k == C_MAX_K));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_t <= '0;
            r_k <= '0;
        end else if (ena) begin
            if (load) begin
                r_t <= t_in;
                r_k <= '0;
            end else if (run && !done) begin
                r_t <= r_t << 1;
                r_k <= r_k + K_W'(1);
            end
        end
    end

    assign k_out  = r_k;
    assign t_norm = r_t;

`endif

endmodule

`default_nettype wire

// File: rtl/logit_approx.sv
// ============================================================================
// Module      : logit_approx
// Description : Inverse of the piecewise-linear sigmoid: Q8.8 probability in,
//               signed Q8.8 logit out. Define LOGIT_FAST_NORM_EN for the
//               fixed-latency leading-one normalizer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logit_approx
    import logit_pkg::*;
#(
    parameter int MAX_SHIFT  = 7,
    parameter int FRAC_SHIFT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    logit_approx_if.slave bus
);

    localparam logic [T_W-1:0] C_T_HALF = T_W'(HALF);

    state_t         r_state;
    logic           r_neg;
    logic [15:0]    r_x;

    logic           w_in_fire;
    logic           w_sat_lo;
    logic           w_sat_hi;
    logic           w_neg;
    logic           w_load;
    logic [T_W-1:0] w_t_load;
    logic           w_done;
    logic [K_W-1:0] w_k;
    logic [T_W-1:0] w_t_norm;
    logic [T_W-1:0] w_resid;
    logic [15:0]    w_frac_wide;
    logic [7:0]     w_frac;
    logic [15:0]    w_mag;
    logic [15:0]    w_x;

    assign w_in_fire = bus.in_valid && (r_state == IDLE) && ena;
    assign w_sat_lo  = (bus.y_in == 16'h0000);
    assign w_sat_hi  = (bus.y_in >= ONE);
    assign w_neg     = (bus.y_in < HALF);
    assign w_load    = w_in_fire && !w_sat_lo && !w_sat_hi;
    assign w_t_load  = w_neg ? {1'b0, bus.y_in[7:0]} : T_W'(ONE - bus.y_in);

    logit_norm #(
        .MAX_SHIFT (MAX_SHIFT)
    ) u_norm (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .load   (w_load),
        .run    (r_state == NORM),
        .t_in   (w_t_load),
        .done   (w_done),
        .k_out  (w_k),
        .t_norm (w_t_norm)
    );

    // An unnormalized residue (only possible with a small MAX_SHIFT) yields frac 0.
    assign w_resid     = (w_t_norm >= C_T_HALF) ? (w_t_norm - C_T_HALF) : '0;
    assign w_frac_wide = 16'(w_resid) << FRAC_SHIFT;
    assign w_frac      = clamp_frac(w_frac_wide);
    assign w_mag       = {w_k, w_frac};
    assign w_x         = r_neg ? (~w_mag + 16'd1) : w_mag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_neg   <= 1'b0;
            r_x     <= 16'h0000;
        end else if (ena) begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (w_sat_lo) begin
                            r_x     <= SAT_NEG;
                            r_state <= DONE;
                        end else if (w_sat_hi) begin
                            r_x     <= SAT_POS;
                            r_state <= DONE;
                        end else begin
                            r_neg   <= w_neg;
                            r_state <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (w_done) begin
                        r_x     <= w_x;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.x_out     = r_x;

endmodule

`default_nettype wire

// File: tb/tb_logit_approx.sv
// ============================================================================
// Module      : tb_logit_approx
// Description : Scoreboard bench for logit_approx with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_logit_approx;

    logic clk;
    logic rst_n;
    logic ena;

    logit_approx_if bus();

    logit_approx #(
        .MAX_SHIFT  (7),
        .FRAC_SHIFT (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] sb[$];
    bit          rand_on = 0;

`ifdef LOGIT_FAST_NORM_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    // Logit from the sigmoid inversion rules, in plain integer arithmetic.
    function automatic logic [15:0] ref_x(input logic [15:0] y, output int k, output bit sat);
        int t, frac, mag;
        bit neg;
        k   = 0;
        sat = 1'b1;
        if (y == 16'h0000) return 16'h8000;
        if (int'(y) >= 256) return 16'h7FFF;
        sat = 1'b0;
        neg = (int'(y) < 128);
        t   = neg ? int'(y) : 256 - int'(y);
        while ((t * (1 << k)) < 128 && k < 7) k++;
        frac = (t * (1 << k) - 128) * 4;
        if (frac > 255) frac = 255;
        if (frac < 0) frac = 0;
        mag = k * 256 + frac;
        return neg ? 16'((65536 - mag) % 65536) : 16'(mag);
    endfunction

    function automatic int ref_lat(input logic [15:0] y);
        int  k;
        bit  sat;
        logic [15:0] x;
        x = ref_x(y, k, sat);
        if (sat) return 1;
        return FAST ? 2 : 2 + k;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every output transfer pops one expectation.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready && ena) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                check("x_out", int'(bus.x_out), int'(sb.pop_front()));
            end
        end
    end

    // With ena low across an edge, visible state must not move.
    logic        p_ena, p_rst, p_ov, p_ir;
    logic [15:0] p_x;
    bit          p_seen = 0;
    always @(negedge clk) begin
        if (p_seen && p_rst && rst_n && !p_ena) begin
            check("hold_state", {int'(bus.out_valid), int'(bus.in_ready), int'(bus.x_out)},
                  {int'(p_ov), int'(p_ir), int'(p_x)});
        end
        p_ena  = ena;
        p_rst  = rst_n;
        p_ov   = bus.out_valid;
        p_ir   = bus.in_ready;
        p_x    = bus.x_out;
        p_seen = 1;
    end

    always begin
        @(posedge clk);
        #1;
        if (rand_on) begin
            ena           = ($urandom_range(0, 9) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic send(input logic [15:0] y, input bit measure, output int lat);
        bit acc;
        int guard;
        int k;
        bit sat;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.y_in     = y;
        acc   = 1'b0;
        guard = 0;
        lat   = 0;
        while (!acc && guard < 300) begin
            @(negedge clk);
            acc = bus.in_ready && ena;
            @(posedge clk);
            guard++;
        end
        if (!acc) begin
            check("accept_timeout", 0, 1);
        end else begin
            check("accept_after_drain", sb.size(), 0);
            sb.push_back(ref_x(y, k, sat));
        end
        #1;
        bus.in_valid = 1'b0;
        bus.y_in     = 16'($urandom);
        if (measure && acc) begin
            lat = 1;
            forever begin
                @(negedge clk);
                if (bus.out_valid || lat > 40) break;
                lat++;
                @(posedge clk);
            end
        end
    endtask

    logic [15:0] edges[8];
    int          lat;
    int          guard;
    bit          seen_ov;

    initial begin
        edges = '{16'h0000, 16'h0001, 16'h007F, 16'h0080,
                  16'h0081, 16'h00FF, 16'h0100, 16'hFFFF};
        rst_n         = 1'b0;
        ena           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.y_in      = 16'h0000;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_x_out", int'(bus.x_out), 0);

        // Directed values with latency; output consumed as soon as valid.
        bus.out_ready = 1'b1;
        send(16'h0080, 1, lat); check("lat_0080", lat, ref_lat(16'h0080));
        send(16'h0020, 1, lat); check("lat_0020", lat, ref_lat(16'h0020));
        send(16'h0000, 1, lat); check("lat_0000", lat, 1);
        send(16'h0140, 1, lat); check("lat_0140", lat, 1);
        send(16'h0001, 1, lat); check("lat_0001", lat, ref_lat(16'h0001));

        // Output stall: held value, no input accepted while DONE.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send(16'h00D0, 1, lat); check("lat_00D0", lat, ref_lat(16'h00D0));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b1;
            bus.y_in     = 16'h0040;
            @(negedge clk);
            check("stall_x_out", int'(bus.x_out), 16'h02FF);
            check("stall_in_ready", int'(bus.in_ready), 0);
            check("stall_out_valid", int'(bus.out_valid), 1);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        send(16'h0040, 1, lat); check("lat_0040", lat, ref_lat(16'h0040));

        // Reset in the middle of normalization discards the pending result.
        send(16'h0001, 0, lat);
        @(negedge clk);
        check("norm_busy", {int'(bus.in_ready), int'(bus.out_valid)}, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", int'(bus.in_ready), 1);
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_x_out", int'(bus.x_out), 0);
        sb.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        seen_ov = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen_ov = 1'b1;
        end
        check("no_valid_after_rst", int'(seen_ov), 0);

        // Randomized traffic with random enable and backpressure.
        rand_on = 1;
        for (int n = 0; n < 150; n++) begin
            logic [15:0] y;
            case ($urandom_range(0, 7))
                0:       y = edges[$urandom_range(0, 7)];
                1:       y = 16'($urandom_range(0, 65535));
                default: y = 16'($urandom_range(1, 255));
            endcase
            send(y, 0, lat);
        end
        @(posedge clk);
        rand_on = 0;
        #1;
        ena           = 1'b1;
        bus.out_ready = 1'b1;
        guard = 0;
        while (sb.size() != 0 && guard < 500) begin
            @(posedge clk);
            guard++;
        end
        check("drain_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
